axis_crc_appender: RTL and testbench
====================================

AXIS_CRC_APPENDER -- requirements
Module: axis_crc_appender

Interface
REQ-001 SHALL have parameter CRC_POLY, default 32'hEDB88320, reflected CRC-32 polynomial.
REQ-002 SHALL have parameter CRC_INIT, default 32'hFFFFFFFF, CRC register value at frame start.
REQ-003 SHALL have parameter CRC_XOROUT, default 32'hFFFFFFFF, XOR applied before append.
REQ-004 SHALL use a single clock CLK_I; reset RST_I is synchronous, active-high.
REQ-005 SHALL have ports:
- CLK_I  in  1  clock
- RST_I  in  1  sync active-high reset
- S_AXIS_TDATA_I  in  8  input payload byte
- S_AXIS_TVALID_I  in  1  input beat valid
- S_AXIS_TLAST_I  in  1  last payload byte of frame
- S_AXIS_TREADY_O  out  1  input accept
- M_AXIS_TDATA_O  out  8  output byte
- M_AXIS_TVALID_O  out  1  output beat valid
- M_AXIS_TLAST_O  out  1  last byte of frame (final CRC byte)
- M_AXIS_TREADY_I  in  1  downstream accept
- FRAME_CNT_O  out  16  frames fully emitted, wraps

Function
REQ-006 SHALL transmit each input frame unchanged, followed by 4 CRC bytes; the output frame length is input length + 4.
REQ-007 SHALL compute the CRC bytewise, LSB-first (reflected): for each bit, crc = (crc>>1) ^ (CRC_POLY if (crc[0]^bit) else 0).
REQ-008 SHALL emit CRC = crc ^ CRC_XOROUT, least significant byte first.
REQ-009 SHALL reset the CRC register to CRC_INIT after the last CRC byte is accepted downstream.
REQ-010 SHALL use a single registered output stage; M_AXIS_* outputs SHALL be driven from flops only.
REQ-011 SHALL transfer a beat when VALID and READY are both high at a rising CLK_I edge, on both sides.
REQ-012 SHALL hold M_AXIS_TDATA_O and M_AXIS_TLAST_O stable, and keep M_AXIS_TVALID_O high, while M_AXIS_TVALID_O=1 and M_AXIS_TREADY_I=0.
REQ-013 SHALL use FSM states PASS and APPEND, with a 2-bit byte index IDX in APPEND.
REQ-014 In PASS, S_AXIS_TREADY_O SHALL equal (!M_AXIS_TVALID_O || M_AXIS_TREADY_I); in APPEND, S_AXIS_TREADY_O SHALL be 0.
REQ-015 An accepted input byte SHALL appear on M_AXIS_TDATA_O in the next cycle with M_AXIS_TLAST_O=0; latency is 1 cycle.
REQ-016 In PASS, an accepted beat with S_AXIS_TLAST_I=1 SHALL update the CRC with that byte, move to APPEND, and set IDX=0.
REQ-017 In APPEND, when the output slot is free (!M_AXIS_TVALID_O || M_AXIS_TREADY_I), the block SHALL load CRC byte IDX and increment IDX.
REQ-018 When IDX=3, the loaded beat SHALL carry M_AXIS_TLAST_O=1, and the FSM SHALL return to PASS.
REQ-019 In PASS, S_AXIS_TREADY_O SHALL re-assert once the output slot is free; the next frame's first byte may then load.
REQ-020 Sustained throughput with M_AXIS_TREADY_I=1 SHALL be 1 byte/cycle; each frame costs exactly 4 extra cycles.
REQ-021 M_AXIS_TVALID_O SHALL clear on an accepted beat when no new beat loads in the same cycle.
REQ-022 FRAME_CNT_O SHALL increment by 1 when a beat with M_AXIS_TLAST_O=1 is accepted, wrapping 16'hFFFF->0.
REQ-023 A 1-byte frame (TLAST on first beat) SHALL be valid and produce 5 output bytes.

Reset
REQ-024 RST_I=1 at a rising edge SHALL set: M_AXIS_TVALID_O=0, M_AXIS_TLAST_O=0, M_AXIS_TDATA_O=0, S_AXIS_TREADY_O=0 during reset, FSM=PASS, IDX=0, CRC=CRC_INIT, FRAME_CNT_O=0.
REQ-025 Reset SHALL take priority over all other events; a frame in progress SHALL be discarded with no CRC emitted.
REQ-026 In the first cycle after reset deassertion, S_AXIS_TREADY_O SHALL be 1.

Verification
REQ-027 Input ASCII "123456789" (0x31..0x39, TLAST on 0x39), M_TREADY=1 -> output 0x31..0x39 then 26 39 F4 CB, TLAST only on CB, FRAME_CNT_O=1.
REQ-028 1-byte frame 0x00 -> output 00 8D EF 02 D2 (CRC 0xD202EF8D), 5 beats, TLAST on D2.
REQ-029 Two back-to-back "123456789" frames, M_TREADY=1 -> 26 output beats, both trailers 26 39 F4 CB, S_TREADY low for exactly 4 cycles per frame.
REQ-030 Random M_AXIS_TREADY_I (50%) and random S_AXIS_TVALID_I gaps on "123456789" -> identical byte sequence, output held stable under backpressure.
REQ-031 Assert RST_I mid-frame, then send "123456789" -> only the clean frame plus 26 39 F4 CB is output; FRAME_CNT_O=1.
REQ-032 Preload by 65536 one-byte frames -> FRAME_CNT_O wraps to 0.

Source files
------------

// File: rtl/axis_crc_appender.sv
`default_nettype none
// ============================================================================
// Module      : axis_crc_appender
// Description : Byte-wide AXI-Stream pass-through that appends a reflected
//               CRC-32 (LSB first) after the last byte of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_crc_appender #(
    parameter logic [31:0] CRC_POLY   = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [7:0]  S_AXIS_TDATA_I,
    input  logic        S_AXIS_TVALID_I,
    input  logic        S_AXIS_TLAST_I,
    output logic        S_AXIS_TREADY_O,
    output logic [7:0]  M_AXIS_TDATA_O,
    output logic        M_AXIS_TVALID_O,
    output logic        M_AXIS_TLAST_O,
    input  logic        M_AXIS_TREADY_I,
    output logic [15:0] FRAME_CNT_O
);

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

    state_t      r_state_q,     w_state_d;
    logic [1:0]  r_idx_q,       w_idx_d;
    logic [31:0] r_crc_q,       w_crc_d;
    logic [7:0]  r_m_tdata_q,   w_m_tdata_d;
    logic        r_m_tvalid_q,  w_m_tvalid_d;
    logic        r_m_tlast_q,   w_m_tlast_d;
    logic [15:0] r_frame_cnt_q, w_frame_cnt_d;

    logic        w_out_free;
    logic        w_s_tready;
    logic        w_in_xfer;
    logic [31:0] w_crc_out;
    logic [31:0] w_crc_shift;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    always_comb begin
        w_out_free  = !r_m_tvalid_q || M_AXIS_TREADY_I;
        w_s_tready  = !RST_I && (r_state_q == PASS) && w_out_free;
        w_in_xfer   = S_AXIS_TVALID_I && w_s_tready;
        w_crc_out   = r_crc_q ^ CRC_XOROUT;
        w_crc_shift = w_crc_out >> {r_idx_q, 3'b000};

        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_crc_d       = r_crc_q;
        w_m_tdata_d   = r_m_tdata_q;
        w_m_tvalid_d  = r_m_tvalid_q;
        w_m_tlast_d   = r_m_tlast_q;
        w_frame_cnt_d = r_frame_cnt_q;

        // Retire the current beat first; a load below may refill the slot.
        if (r_m_tvalid_q && M_AXIS_TREADY_I) begin
            w_m_tvalid_d = 1'b0;
            w_m_tlast_d  = 1'b0;
            if (r_m_tlast_q) begin
                w_frame_cnt_d = r_frame_cnt_q + 16'd1;
            end
        end

        case (r_state_q)
            PASS: begin
                if (w_in_xfer) begin
                    w_m_tdata_d  = S_AXIS_TDATA_I;
                    w_m_tvalid_d = 1'b1;
                    w_m_tlast_d  = 1'b0;
                    w_crc_d      = crc_byte(r_crc_q, S_AXIS_TDATA_I);
                    if (S_AXIS_TLAST_I) begin
                        w_state_d = APPEND;
                        w_idx_d   = 2'd0;
                    end
                end
            end
            APPEND: begin
                if (w_out_free) begin
                    w_m_tdata_d  = w_crc_shift[7:0];
                    w_m_tvalid_d = 1'b1;
                    w_m_tlast_d  = (r_idx_q == 2'd3);
                    w_idx_d      = r_idx_q + 2'd1;
                    // The trailer is fully captured in the output stage, so
                    // the CRC can be re-seeded for the next frame right away.
                    if (r_idx_q == 2'd3) begin
                        w_state_d = PASS;
                        w_crc_d   = CRC_INIT;
                    end
                end
            end
            default: begin
                w_state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state_q     <= PASS;
            r_idx_q       <= 2'd0;
            r_crc_q       <= CRC_INIT;
            r_m_tdata_q   <= 8'h00;
            r_m_tvalid_q  <= 1'b0;
            r_m_tlast_q   <= 1'b0;
            r_frame_cnt_q <= 16'h0000;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_crc_q       <= w_crc_d;
            r_m_tdata_q   <= w_m_tdata_d;
            r_m_tvalid_q  <= w_m_tvalid_d;
            r_m_tlast_q   <= w_m_tlast_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    assign S_AXIS_TREADY_O = w_s_tready;
    assign M_AXIS_TDATA_O  = r_m_tdata_q;
    assign M_AXIS_TVALID_O = r_m_tvalid_q;
    assign M_AXIS_TLAST_O  = r_m_tlast_q;
    assign FRAME_CNT_O     = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_crc_appender.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_crc_appender
// Description : Self-checking bench for axis_crc_appender with a frame-level
//               CRC reference model and random stimulus / backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_crc_appender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    axis_crc_appender dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .S_AXIS_TDATA_I  (s_tdata),
        .S_AXIS_TVALID_I (s_tvalid),
        .S_AXIS_TLAST_I  (s_tlast),
        .S_AXIS_TREADY_O (s_tready),
        .M_AXIS_TDATA_O  (m_tdata),
        .M_AXIS_TVALID_O (m_tvalid),
        .M_AXIS_TLAST_O  (m_tlast),
        .M_AXIS_TREADY_I (m_tready),
        .FRAME_CNT_O     (frame_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_pct = 100;
    int hold_viol = 0;
    int sready_low = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic [7:0] str9[$];

    // Downstream ready generator: changes only just after a rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = ($urandom_range(99) < ready_pct);
        end
    end

    // Output monitor: records accepted beats and watches stall stability.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data
                                   || m_tlast !== prev_last))
                    hold_viol++;
                if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
                if (!s_tready) sready_low++;
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    // Reference: reflected CRC-32 over the whole frame, final XOR applied.
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ q[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                c = c >> 1;
            end
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    function automatic void add_expected(input logic [7:0] q[$]);
        logic [31:0] c;
        c = ref_crc(q);
        foreach (q[i]) exp_q.push_back({1'b0, q[i]});
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(k == 3), 8'((c >> (8 * k)) & 32'hFF)});
    endfunction

    // Drives one frame; caller is positioned just after a rising edge.
    task automatic send_frame(input logic [7:0] q[$], input bit with_last,
                              input int gap_pct);
        for (int i = 0; i < q.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata  = q[i];
            s_tlast  = with_last && (i == q.size() - 1);
            s_tvalid = 1'b1;
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!s_tready && t < 1000);
                if (!s_tready) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout s_tready got %b want 1", s_tready);
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
        n_cmp++; if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got %h want 00", m_tdata); end
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_sready got %b want 0", s_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_sready got %b want 1", s_tready); end
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_frame_cnt got %h want 0000", frame_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_check_string();
        logic [8:0] lit[$];
        lit = '{9'h026, 9'h039, 9'h0F4, 9'h1CB};
        ready_pct = 100;
        got.delete(); exp_q.delete(); sready_low = 0;
        add_expected(str9);
        send_frame(str9, 1'b1, 0);
        wait_beats(exp_q.size());
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL str_len got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL str_beat[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        for (int i = 0; i < 4 && 9 + i < got.size(); i++) begin
            n_cmp++; if (got[9+i] !== lit[i]) begin n_err++; $display("FAIL str_trailer[%0d] got %h want %h", i, got[9+i], lit[i]); end
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL str_frame_cnt got %0d want 1", frame_cnt); end
        n_cmp++; if (sready_low !== 4) begin n_err++; $display("FAIL str_sready_low got %0d want 4", sready_low); end
    endtask

    task automatic test_one_byte();
        logic [7:0] one[$];
        logic [8:0] lit[$];
        one = '{8'h00};
        lit = '{9'h000, 9'h08D, 9'h0EF, 9'h002, 9'h1D2};
        got.delete();
        send_frame(one, 1'b1, 0);
        wait_beats(5);
        n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL one_len got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== lit[i]) begin n_err++; $display("FAIL one_beat[%0d] got %h want %h", i, got[i], lit[i]); end
        end
        n_cmp++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL one_frame_cnt got %0d want 2", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        got.delete(); exp_q.delete(); sready_low = 0;
        add_expected(str9);
        add_expected(str9);
        send_frame(str9, 1'b1, 0);
        send_frame(str9, 1'b1, 0);
        wait_beats(26);
        n_cmp++; if (got.size() !== 26) begin n_err++; $display("FAIL b2b_len got %0d want 26", got.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_beat[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (sready_low !== 8) begin n_err++; $display("FAIL b2b_sready_low got %0d want 8", sready_low); end
        n_cmp++; if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL b2b_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_backpressure();
        got.delete(); exp_q.delete(); hold_viol = 0;
        ready_pct = 50;
        for (int f = 0; f < 6; f++) begin
            logic [7:0] fr[$];
            if (f == 0) fr = str9;
            else begin
                int len;
                len = $urandom_range(20, 1);
                for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            end
            add_expected(fr);
            send_frame(fr, 1'b1, 30);
        end
        wait_beats(exp_q.size());
        ready_pct = 100;
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_len got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL bp_hold got %0d violations want 0", hold_viol); end
        n_cmp++; if (frame_cnt !== 16'd10) begin n_err++; $display("FAIL bp_frame_cnt got %0d want 10", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part[$];
        part = str9[0:4];
        ready_pct = 100;
        send_frame(part, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete(); exp_q.delete();
        add_expected(str9);
        send_frame(str9, 1'b1, 0);
        wait_beats(13);
        n_cmp++; if (got.size() !== 13) begin n_err++; $display("FAIL mid_len got %0d want 13", got.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_beat[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL mid_frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] one[$];
        force dut.r_frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_frame_cnt_q;
        one = '{8'($urandom)};
        got.delete();
        send_frame(one, 1'b1, 0);
        wait_beats(5);
        n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h want ffff", frame_cnt); end
        got.delete();
        send_frame(one, 1'b1, 0);
        wait_beats(5);
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", frame_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) str9.push_back(8'h31 + 8'(i));
        test_reset();
        test_check_string();
        test_one_byte();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
